// File: rtl/bus_endpoint_fifo_if.sv
// Bus and user-side signal bundle for bus_endpoint_fifo.
// The slave modport is the endpoint; master is the bus/user environment driving it.
interface bus_endpoint_fifo_if #(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned depth   = 8
);
  localparam int unsigned CW = $clog2(depth) + 1;

  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               tx_wr;
  logic [pckg_sz-1:0] tx_data;
  logic               tx_full;
  logic               rx_rd;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_valid;
  logic [CW-1:0]      tx_count;
  logic [CW-1:0]      rx_count;
  logic               tx_ovf;
  logic               rx_ovf;
  logic               rx_misaddr;
  logic               clr_flags;

  modport slave (
    input  pop, push, D_push, tx_wr, tx_data, rx_rd, clr_flags,
    output pndng, D_pop, tx_full, rx_data, rx_valid, tx_count, rx_count,
           tx_ovf, rx_ovf, rx_misaddr
  );

  modport master (
    output pop, push, D_push, tx_wr, tx_data, rx_rd, clr_flags,
    input  pndng, D_pop, tx_full, rx_data, rx_valid, tx_count, rx_count,
           tx_ovf, rx_ovf, rx_misaddr
  );
endinterface

// File: rtl/bus_endpoint_fifo.sv
// Bus endpoint with a TX FIFO (user -> bus) and an address-filtered RX FIFO (bus -> user).
// Both FIFOs are first-word-fall-through with sticky overflow / misaddress flags.
module bus_endpoint_fifo #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = {8{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  bus_endpoint_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(depth);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];

  logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d, tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d, rx_wr_ptr_q, rx_wr_ptr_d;
  logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_misaddr_q, rx_misaddr_d;

  logic tx_empty, tx_full, tx_do_pop, tx_do_wr, tx_ovf_set;
  logic rx_empty, rx_full, rx_match, rx_do_rd, rx_do_wr, rx_ovf_set, rx_misaddr_set;
  logic [7:0] dest;

  // TX side: a pop on a full FIFO frees the slot the concurrent write lands in.
  always_comb begin
    tx_empty   = (tx_count_q == '0);
    tx_full    = (tx_count_q == FullCount);
    tx_do_pop  = bus.pop && !tx_empty;
    tx_do_wr   = bus.tx_wr && (!tx_full || tx_do_pop);
    tx_ovf_set = bus.tx_wr && tx_full && !bus.pop;

    tx_rd_ptr_d = tx_do_pop ? tx_rd_ptr_q + AW'(1) : tx_rd_ptr_q;
    tx_wr_ptr_d = tx_do_wr  ? tx_wr_ptr_q + AW'(1) : tx_wr_ptr_q;
    tx_count_d  = tx_count_q;
    unique case ({tx_do_wr, tx_do_pop})
      2'b10:   tx_count_d = tx_count_q + CW'(1);
      2'b01:   tx_count_d = tx_count_q - CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
    tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~bus.clr_flags);
  end

  // RX side: only packets addressed to us or to broadcast are considered.
  always_comb begin
    dest           = bus.D_push[pckg_sz-1 -: 8];
    rx_match       = (dest == id) || (dest == broadcast);
    rx_empty       = (rx_count_q == '0);
    rx_full        = (rx_count_q == FullCount);
    rx_do_rd       = bus.rx_rd && !rx_empty;
    rx_do_wr       = bus.push && rx_match && (!rx_full || rx_do_rd);
    rx_ovf_set     = bus.push && rx_match && rx_full && !bus.rx_rd;
    rx_misaddr_set = bus.push && !rx_match;

    rx_rd_ptr_d = rx_do_rd ? rx_rd_ptr_q + AW'(1) : rx_rd_ptr_q;
    rx_wr_ptr_d = rx_do_wr ? rx_wr_ptr_q + AW'(1) : rx_wr_ptr_q;
    rx_count_d  = rx_count_q;
    unique case ({rx_do_wr, rx_do_rd})
      2'b10:   rx_count_d = rx_count_q + CW'(1);
      2'b01:   rx_count_d = rx_count_q - CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
    rx_ovf_d     = rx_ovf_set | (rx_ovf_q & ~bus.clr_flags);
    rx_misaddr_d = rx_misaddr_set | (rx_misaddr_q & ~bus.clr_flags);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_rd_ptr_q  <= '0;
      tx_wr_ptr_q  <= '0;
      tx_count_q   <= '0;
      rx_rd_ptr_q  <= '0;
      rx_wr_ptr_q  <= '0;
      rx_count_q   <= '0;
      tx_ovf_q     <= 1'b0;
      rx_ovf_q     <= 1'b0;
      rx_misaddr_q <= 1'b0;
    end else begin
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_count_q   <= tx_count_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_count_q   <= rx_count_d;
      tx_ovf_q     <= tx_ovf_d;
      rx_ovf_q     <= rx_ovf_d;
      rx_misaddr_q <= rx_misaddr_d;
    end
  end

  // Storage needs no reset: heads are masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (tx_do_wr) tx_mem[tx_wr_ptr_q] <= bus.tx_data;
    if (rx_do_wr) rx_mem[rx_wr_ptr_q] <= bus.D_push;
  end

  assign bus.pndng      = !tx_empty;
  assign bus.D_pop      = tx_empty ? '0 : tx_mem[tx_rd_ptr_q];
  assign bus.tx_full    = tx_full;
  assign bus.tx_count   = tx_count_q;
  assign bus.tx_ovf     = tx_ovf_q;
  assign bus.rx_valid   = !rx_empty;
  assign bus.rx_data    = rx_empty ? '0 : rx_mem[rx_rd_ptr_q];
  assign bus.rx_count   = rx_count_q;
  assign bus.rx_ovf     = rx_ovf_q;
  assign bus.rx_misaddr = rx_misaddr_q;
endmodule

// File: doc/bus_endpoint_fifo.md
BUS_ENDPOINT_FIFO -- requirements
Module: bus_endpoint_fifo

Interface
REQ-001 Parameter pckg_sz, default 16: packet width in bits; dest address is D_push[pckg_sz-1 -: 8].
REQ-002 Parameter depth, default 8: entries per FIFO; a power of 2, at least 2.
REQ-003 Parameter id, default 0: 8-bit address of this endpoint.
REQ-004 Parameter broadcast, default {8{1'b1}}: dest address accepted by every endpoint.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 pndng  out  1  TX FIFO non-empty; a packet is offered to the bus.
REQ-008 D_pop  out  pckg_sz  TX FIFO head (first-word-fall-through).
REQ-009 pop  in  1  bus consumes the TX head this cycle.
REQ-010 push  in  1  bus delivers D_push this cycle.
REQ-011 D_push  in  pckg_sz  packet from the bus.
REQ-012 tx_wr  in  1  user writes tx_data into the TX FIFO.
REQ-013 tx_data  in  pckg_sz  user packet to send.
REQ-014 tx_full  out  1  TX FIFO holds depth entries.
REQ-015 rx_rd  in  1  user consumes the RX head.
REQ-016 rx_data  out  pckg_sz  RX FIFO head (first-word-fall-through).
REQ-017 rx_valid  out  1  RX FIFO non-empty.
REQ-018 tx_count, rx_count  out  $clog2(depth)+1 each  FIFO occupancies.
REQ-019 tx_ovf, rx_ovf, rx_misaddr  out  1 each  sticky error flags.
REQ-020 clr_flags  in  1  synchronous clear of the three sticky flags.

Function
REQ-021 The TX FIFO SHALL be circular, with rd/wr pointers that wrap modulo depth and an occupancy counter.
REQ-022 pndng SHALL equal (tx_count != 0), and D_pop SHALL be the TX head combinationally.
REQ-023 pop with pndng=1 SHALL advance the TX head; pop with pndng=0 SHALL be ignored with no state change.
REQ-024 tx_wr with tx_full=0 SHALL store tx_data; tx_wr with tx_full=1 and pop=0 SHALL be dropped and set tx_ovf.
REQ-025 tx_wr and pop in the same cycle when full SHALL both take effect; tx_count is unchanged and no overflow occurs.
REQ-026 tx_wr and pop in the same cycle when empty SHALL accept the write only; tx_count becomes 1 and pndng rises the next cycle.
REQ-027 An incoming push SHALL be accepted only if dest == id or dest == broadcast; otherwise it is discarded and rx_misaddr is set.
REQ-028 An accepted push with RX not full, or full with rx_rd=1 in the same cycle, SHALL store D_push.
REQ-029 An accepted push with RX full and rx_rd=0 SHALL be dropped and set rx_ovf.
REQ-030 rx_rd with rx_valid=0 SHALL be ignored.
REQ-031 rx_valid SHALL equal (rx_count != 0), and rx_data SHALL be the RX head combinationally.
REQ-032 Write-to-read latency SHALL be 1 cycle for both FIFOs: data written at edge N is visible on the head outputs after edge N.
REQ-033 Each count SHALL be updated by +1, -1 or 0 per cycle and never exceed depth or go below 0.
REQ-034 clr_flags SHALL clear the flags on the next edge; if an error event occurs in the same cycle, the set wins.
REQ-035 Packet contents SHALL pass unmodified in both directions, and FIFO order SHALL be preserved.

Reset
REQ-036 While reset=1, the following SHALL be forced low or zero, and pops, pushes, writes and reads SHALL be ignored:
- pndng, tx_full, rx_valid
- tx_count, rx_count
- all flags
- all pointers
REQ-037 D_pop and rx_data SHALL read 0 while their FIFO is empty after reset.
REQ-038 Reset asserted mid-operation SHALL discard all buffered packets, and no pop or push SHALL complete in that cycle.

Verification
REQ-039 Reset, then one tx_wr of 16'h02AB with id=2 -> next cycle pndng=1, D_pop=16'h02AB; one pop -> pndng=0, tx_count=0.
REQ-040 Eight tx_wr at depth=8 -> tx_full=1; a ninth tx_wr alone -> tx_ovf=1, tx_count=8; then tx_wr+pop together -> tx_count=8, tx_ovf unchanged.
REQ-041 push of 16'h02CD, 16'hFF11 and 16'h0333 with id=2 -> rx_count=2 with order CD then 11, and rx_misaddr=1.
REQ-042 Nine accepted pushes with rx_rd=0 -> rx_ovf=1, rx_count=8; clr_flags -> rx_ovf=0 next cycle.
REQ-043 Fill TX with 3 entries, then assert reset asynchronously between edges -> pndng and tx_count drop to 0 before the next edge.
REQ-044 Random tx_wr/pop/push/rx_rd for 1000 cycles against a reference queue model -> data and order match, with counts never above 8.
